fetch_sequencer: RTL and testbench

Instruction fetch sequencer for the RV32E core. It owns the program counter, drives the word address of the combinational program ROM, and buffers fetched words in a small prefetch FIFO. It presents instructions to decode over a valid/ready handshake. Decode or execute requests branch/jump redirects, which flush the FIFO and restart fetch; any fetch outside the ROM, or any misaligned target, parks the block in a fault state.

---
 rtl/fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch sequencer. Owns the program counter, addresses the
//   combinational program ROM, buffers fetched words in a small prefetch FIFO
//   and hands them to decode over a valid/ready handshake. Redirects flush
//   the FIFO and restart fetch. A fetch beyond the ROM or a misaligned
//   redirect target parks the block in FAULT until an aligned redirect.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   fetch_en        : allows new words to be pushed
//   rom_addr/data   : ROM word index (from pc) and same-cycle read data
//   instr_valid     : FIFO head valid
//   instr_ready     : decode accepts the head
//   instr/instr_pc  : head word and its byte address (0 when empty)
//   redirect_valid  : one-cycle fetch restart request
//   redirect_pc     : byte target of the redirect
//   fetch_fault     : high while in FAULT
//   fetch_count     : words pushed, wraps modulo 2^32
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 513,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [30:0]   ROM_WORDS_C = 31'(ROM_WORDS);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [31:0]     fcount_q, fcount_d;
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     addr_q [DEPTH];

    logic pop;
    logic space;
    logic oob;
    logic fetch_try;
    logic push;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign instr_valid = (count_q != '0);
    assign rom_addr    = {2'b00, pc_q[31:2]};
    assign instr       = instr_valid ? data_q[head_q] : '0;
    assign instr_pc    = instr_valid ? addr_q[head_q] : '0;
    assign fetch_fault = (state_q == FAULT);
    assign fetch_count = fcount_q;

    always_comb begin
        pop       = instr_valid & instr_ready;
        space     = (count_q < DEPTH_C) | pop;
        oob       = ({1'b0, pc_q[31:2]} >= ROM_WORDS_C);
        fetch_try = (state_q == RUN) & ~redirect_valid & fetch_en & space;
        push      = fetch_try & ~oob;

        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        fcount_d = fcount_q;

        if (redirect_valid) begin
            // A same-cycle pop has already been taken by decode; everything
            // left in the FIFO is stale and dropped.
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            pc_d    = redirect_pc;
            state_d = (redirect_pc[1:0] == 2'b00) ? RUN : FAULT;
        end else begin
            if (fetch_try && oob) begin
                state_d = FAULT;
            end
            if (push) begin
                pc_d     = pc_q + 32'd4;
                tail_d   = ptr_inc(tail_q);
                fcount_d = fcount_q + 32'd1;
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            fcount_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            fcount_q <= fcount_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (push) begin
            data_q[tail_q] <= rom_data;
            addr_q[tail_q] <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer (defaults: RESET_PC=0,
// ROM_WORDS=513, DEPTH=2). Outputs are sampled 1 time unit after each
// rising edge; inputs changed at that point take effect on the next edge.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .ROM_WORDS(513),
        .DEPTH    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_fault   (fetch_fault),
        .fetch_count   (fetch_count)
    );

    // ROM: word 0 is ADDI x1,x0,1; word i>0 is ADDI x0,x0,i (a NOP whose
    // immediate tags the word index so misordered words are visible).
    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        if (idx == 32'd0) return 32'h0010_0093;
        return {idx[11:0], 20'h0_0013};
    endfunction

    assign rom_data = rom_word(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        tick();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_romaddr", rom_addr, 32'd0);
        tick();
        rst = 1'b0;

        // Streaming from reset: one instruction per cycle
        tick();
        check("s1_valid", 32'(instr_valid), 32'd1);
        check("s1_instr", instr, 32'h0010_0093);
        check("s1_pc", instr_pc, 32'd0);
        check("s1_count", fetch_count, 32'd1);
        check("s1_romaddr", rom_addr, 32'd1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check("s_valid", 32'(instr_valid), 32'd1);
            check("s_pc", instr_pc, 32'(4 * (k - 1)));
            check("s_instr", instr, rom_word(32'(k - 1)));
            check("s_count", fetch_count, 32'(k));
        end

        // Backpressure from reset: two pushes, then hold
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(instr_valid), 32'd0);
        instr_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("bp_count", fetch_count, 32'd2);
        check("bp_romaddr", rom_addr, 32'd2);
        check("bp_pc", instr_pc, 32'd0);
        check("bp_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        tick();
        check("rel_pc4", instr_pc, 32'd4);
        check("rel_valid4", 32'(instr_valid), 32'd1);
        check("rel_count3", fetch_count, 32'd3);
        tick();
        check("rel_pc8", instr_pc, 32'd8);
        check("rel_valid8", 32'(instr_valid), 32'd1);
        check("rel_count4", fetch_count, 32'd4);
        tick();
        check("rel_pc12", instr_pc, 32'd12);
        check("rel_count5", fetch_count, 32'd5);

        // Redirect to 0x40 while popping pc 12 (pc 16 is stale)
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("rd_valid0", 32'(instr_valid), 32'd0);
        check("rd_pc0", instr_pc, 32'd0);
        check("rd_romaddr", rom_addr, 32'h10);
        check("rd_count", fetch_count, 32'd5);
        tick();
        check("rd_valid1", 32'(instr_valid), 32'd1);
        check("rd_pc40", instr_pc, 32'h40);
        check("rd_instr40", instr, rom_word(32'd16));
        check("rd_count6", fetch_count, 32'd6);
        tick();
        check("rd_pc44", instr_pc, 32'h44);
        check("rd_count7", fetch_count, 32'd7);

        // Out-of-range fetch
        redirect_valid = 1'b1;
        redirect_pc    = 32'h800;
        tick();
        redirect_valid = 1'b0;
        check("oob_valid0", 32'(instr_valid), 32'd0);
        check("oob_romaddr", rom_addr, 32'd512);
        tick();
        check("oob_pc512", instr_pc, 32'h800);
        check("oob_instr512", instr, rom_word(32'd512));
        check("oob_valid512", 32'(instr_valid), 32'd1);
        check("oob_fault0", 32'(fetch_fault), 32'd0);
        check("oob_count8", fetch_count, 32'd8);
        tick();
        check("oob_fault1", 32'(fetch_fault), 32'd1);
        check("oob_valid_f", 32'(instr_valid), 32'd0);
        check("oob_count_f", fetch_count, 32'd8);
        tick();
        check("oob_fault_hold", 32'(fetch_fault), 32'd1);
        check("oob_count_hold", fetch_count, 32'd8);
        check("oob_romaddr513", rom_addr, 32'd513);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h804;
        tick();
        redirect_valid = 1'b0;
        check("oob2_fault0", 32'(fetch_fault), 32'd0);
        check("oob2_valid0", 32'(instr_valid), 32'd0);
        tick();
        check("oob2_fault1", 32'(fetch_fault), 32'd1);
        check("oob2_count", fetch_count, 32'd8);
        check("oob2_valid", 32'(instr_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        check("clr_fault", 32'(fetch_fault), 32'd0);
        check("clr_romaddr", rom_addr, 32'd0);
        tick();
        check("clr_valid", 32'(instr_valid), 32'd1);
        check("clr_pc", instr_pc, 32'd0);
        check("clr_instr", instr, 32'h0010_0093);
        check("clr_count", fetch_count, 32'd9);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        tick();
        redirect_valid = 1'b0;
        check("mis_fault", 32'(fetch_fault), 32'd1);
        check("mis_valid", 32'(instr_valid), 32'd0);
        check("mis_romaddr", rom_addr, 32'd1);
        repeat (3) begin
            tick();
            check("mis_hold_valid", 32'(instr_valid), 32'd0);
            check("mis_hold_count", fetch_count, 32'd9);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        tick();
        redirect_valid = 1'b0;
        check("mis_clr_fault", 32'(fetch_fault), 32'd0);
        check("mis_clr_valid", 32'(instr_valid), 32'd0);
        tick();
        check("mis_rs_valid", 32'(instr_valid), 32'd1);
        check("mis_rs_pc", instr_pc, 32'd8);
        check("mis_rs_instr", instr, rom_word(32'd2));
        check("mis_rs_count", fetch_count, 32'd10);

        // Asynchronous reset with a full FIFO
        instr_ready = 1'b0;
        tick();
        tick();
        check("full_count", fetch_count, 32'd11);
        check("full_pc", instr_pc, 32'd8);
        check("full_romaddr", rom_addr, 32'd4);
        #3;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(instr_valid), 32'd0);
        check("ar_instr", instr, 32'd0);
        check("ar_pc", instr_pc, 32'd0);
        check("ar_fault", 32'(fetch_fault), 32'd0);
        check("ar_count", fetch_count, 32'd0);
        check("ar_romaddr", rom_addr, 32'd0);
        tick();
        rst         = 1'b0;
        instr_ready = 1'b1;
        tick();
        check("ar_rs_valid", 32'(instr_valid), 32'd1);
        check("ar_rs_pc", instr_pc, 32'd0);
        check("ar_rs_count", fetch_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
